pkt_hdr_builder: RTL

- Transmit-side counterpart of the p2p header parser in box_250mhz.
- Accepts a header descriptor plus a payload-only AXI4-Stream, and emits a 512-bit AXI4-Stream frame: Ethernet + IPv4/IPv6 + L4 ports header, then the payload.
- The payload is realigned behind the 38-byte (IPv4) or 58-byte (IPv6) header.
- Fills the length fields and computes the IPv4 header checksum.

---
 rtl/pkt_hdr_builder.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/pkt_hdr_builder.sv
// Transmit header builder: prepends Ethernet + IPv4/IPv6 + L4 ports to a payload stream
// and realigns the payload behind the 38- or 58-byte header on a 512-bit AXI4-Stream.
module pkt_hdr_builder #(
    parameter int unsigned DATA_W  = 512,
    parameter logic [7:0]  DEF_TTL = 8'h40
) (
    input  logic                  axis_aclk,
    input  logic                  axis_rst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic                  desc_is_ipv6,
    input  logic [47:0]           desc_dst_mac,
    input  logic [47:0]           desc_src_mac,
    input  logic [127:0]          desc_src_ip,
    input  logic [127:0]          desc_dst_ip,
    input  logic [7:0]            desc_protocol,
    input  logic [15:0]           desc_src_port,
    input  logic [15:0]           desc_dst_port,
    input  logic [15:0]           desc_payload_len,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    input  logic [DATA_W-1:0]     s_axis_tdata,
    input  logic [DATA_W/8-1:0]   s_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [DATA_W-1:0]     m_axis_tdata,
    output logic [DATA_W/8-1:0]   m_axis_tkeep
);
    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned H4     = 38;
    localparam int unsigned H6     = 58;
    localparam int unsigned HDR4_W = 8 * H4;
    localparam int unsigned HDR6_W = 8 * H6;
    localparam logic [KEEP_W-1:0] HMASK4 = KEEP_W'((64'(1) << H4) - 64'(1));
    localparam logic [KEEP_W-1:0] HMASK6 = KEEP_W'((64'(1) << H6) - 64'(1));

    typedef enum logic [2:0] {S_IDLE, S_CSUM, S_HDR, S_BODY, S_FLUSH} state_t;
    state_t state_q, state_d;

    logic          is_ipv6_q;
    logic [47:0]   dst_mac_q, src_mac_q;
    logic [127:0]  src_ip_q, dst_ip_q;
    logic [7:0]    proto_q;
    logic [15:0]   sport_q, dport_q, plen_q;
    logic [15:0]   csum_q;
    logic [DATA_W-1:0] residue_q;
    logic [KEEP_W-1:0] res_keep_q;

    logic [15:0]       ip_len4, ip_len6;
    logic [31:0]       csum_sum, fold1;
    logic [15:0]       fold2;
    logic [HDR4_W-1:0] v4_be;
    logic [HDR6_W-1:0] v6_be;
    logic [DATA_W-1:0] hdr;
    logic [DATA_W-1:0] shift_data, res_data, beat_data;
    logic [KEEP_W-1:0] shift_keep, res_keep, beat_keep;
    logic              spill, out_free, s_rdy, load, beat_last;

    // IPv4 header checksum over the ten header words, checksum word as zero
    assign ip_len4  = 16'(plen_q + 16'd24);
    assign ip_len6  = 16'(plen_q + 16'd4);
    assign csum_sum = 32'h4500 + 32'(ip_len4) + 32'h4000 + 32'({DEF_TTL, proto_q})
                    + 32'(src_ip_q[31:16]) + 32'(src_ip_q[15:0])
                    + 32'(dst_ip_q[31:16]) + 32'(dst_ip_q[15:0]);
    assign fold1    = 32'(csum_sum[15:0]) + 32'(csum_sum[31:16]);
    assign fold2    = fold1[15:0] + fold1[31:16];

    // Headers written first-byte-at-MSB, then byte-reversed onto the wire order
    assign v4_be = {dst_mac_q, src_mac_q, 16'h0800, 8'h45, 8'h00, ip_len4, 16'h0000,
                    16'h4000, DEF_TTL, proto_q, csum_q, src_ip_q[31:0], dst_ip_q[31:0],
                    sport_q, dport_q};
    assign v6_be = {dst_mac_q, src_mac_q, 16'h86DD, 32'h6000_0000, ip_len6, proto_q,
                    DEF_TTL, src_ip_q, dst_ip_q, sport_q, dport_q};

    always_comb begin
        hdr = '0;
        if (is_ipv6_q) begin
            for (int unsigned k = 0; k < H6; k++) hdr[8*k +: 8] = v6_be[HDR6_W-8-8*k +: 8];
        end else begin
            for (int unsigned k = 0; k < H4; k++) hdr[8*k +: 8] = v4_be[HDR4_W-8-8*k +: 8];
        end
    end

    // Payload bytes slide up by H; the top H bytes spill into the residue
    assign shift_data = is_ipv6_q ? (s_axis_tdata << HDR6_W) : (s_axis_tdata << HDR4_W);
    assign shift_keep = is_ipv6_q ? ((s_axis_tkeep << H6) | HMASK6)
                                  : ((s_axis_tkeep << H4) | HMASK4);
    assign res_data   = is_ipv6_q ? (s_axis_tdata >> (DATA_W - HDR6_W))
                                  : (s_axis_tdata >> (DATA_W - HDR4_W));
    assign res_keep   = is_ipv6_q ? (s_axis_tkeep >> (KEEP_W - H6))
                                  : (s_axis_tkeep >> (KEEP_W - H4));
    assign spill      = is_ipv6_q ? s_axis_tkeep[KEEP_W-H6] : s_axis_tkeep[KEEP_W-H4];
    assign out_free   = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = s_rdy;

    always_comb begin
        state_d   = state_q;
        s_rdy     = 1'b0;
        load      = 1'b0;
        beat_last = 1'b0;
        beat_data = shift_data | ((state_q == S_HDR) ? hdr : residue_q);
        beat_keep = shift_keep;
        case (state_q)
            S_IDLE:  if (desc_valid && desc_ready) state_d = S_CSUM;
            S_CSUM:  state_d = S_HDR;
            S_HDR, S_BODY: begin
                s_rdy = out_free;
                if (s_axis_tvalid && out_free) begin
                    load = 1'b1;
                    if (s_axis_tlast && !spill) begin
                        beat_last = 1'b1;
                        state_d   = S_IDLE;
                    end else if (s_axis_tlast) begin
                        state_d = S_FLUSH;
                    end else begin
                        state_d = S_BODY;
                    end
                end
            end
            S_FLUSH: begin
                beat_data = residue_q;
                beat_keep = res_keep_q;
                if (out_free) begin
                    load      = 1'b1;
                    beat_last = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (axis_rst) begin
            s_rdy = 1'b0;
            load  = 1'b0;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (axis_rst) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Registered AXIS master; holds the beat until the sink takes it
    always_ff @(posedge axis_aclk) begin
        if (axis_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            desc_ready    <= 1'b0;
            res_keep_q    <= '0;
        end else begin
            desc_ready <= (state_d == S_IDLE);
            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= beat_last;
                m_axis_tdata  <= beat_data;
                m_axis_tkeep  <= beat_keep;
            end else if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            if (load && (state_q != S_FLUSH)) res_keep_q <= res_keep;
        end
    end

    always_ff @(posedge axis_aclk) begin
        if (desc_valid && desc_ready && (state_q == S_IDLE)) begin
            is_ipv6_q <= desc_is_ipv6;
            dst_mac_q <= desc_dst_mac;
            src_mac_q <= desc_src_mac;
            src_ip_q  <= desc_src_ip;
            dst_ip_q  <= desc_dst_ip;
            proto_q   <= desc_protocol;
            sport_q   <= desc_src_port;
            dport_q   <= desc_dst_port;
            plen_q    <= desc_payload_len;
        end
        if (state_q == S_CSUM) csum_q <= ~fold2;
        if (load && (state_q != S_FLUSH)) residue_q <= res_data;
    end
endmodule
